boot_loader: RTL and testbench

Upstream stage of `core`: fills the tagged-cell RAM from a framed byte stream before execution is allowed to start. The byte stream comes from the board UART receiver. The block assembles 16-bit cells and writes them from address 0 upward, then verifies a checksum. `boot_done` gates `btn_start` in `core`; the core's memory port is muxed to this block while `boot_done` is low.

---
 rtl/lisp.sv | 27 ++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisp.sv
// Shared core definitions: cell width plus the boot loader state and error encodings.
// Pure type/constant package, no logic.
package lisp;

    localparam int data_width = 16;

    localparam logic [7:0] BOOT_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        BOOT_IDLE    = 3'd0,
        BOOT_LEN_HI  = 3'd1,
        BOOT_LEN_LO  = 3'd2,
        BOOT_DATA_HI = 3'd3,
        BOOT_DATA_LO = 3'd4,
        BOOT_CHECK   = 3'd5,
        BOOT_DONE    = 3'd6,
        BOOT_ERROR   = 3'd7
    } boot_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } boot_err_t;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: assembles 16-bit cells from a framed UART byte stream into RAM, then checks an XOR checksum.
// Latency: write strobe and done/error flags appear one cycle after the deciding byte handshake.
// Backpressure: rx_ready stays high in every loading state (one byte per cycle); it drops in Done/Error.
module boot_loader
    import lisp::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int MEM_SIZE       = 1024,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter bit BYPASS_BOOT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  boot_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [1:0]            error_code
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam boot_state_t RESET_STATE = BYPASS_BOOT ? BOOT_DONE : BOOT_IDLE;

    boot_state_t   state_q, state_d;
    boot_err_t     err_q, err_d;
    logic [7:0]    len_hi_q, hi_q, csum_q;
    logic [15:0]   len_q, idx_q, len_w;
    logic [TW-1:0] tmo_q;
    logic          hs, counting, len_bad, last_word;

    assign rx_ready   = (state_q != BOOT_DONE) && (state_q != BOOT_ERROR);
    assign hs         = rx_valid && rx_ready;
    assign counting   = rx_ready && (state_q != BOOT_IDLE);
    assign len_w      = {len_hi_q, rx_data};
    assign len_bad    = (len_w == 16'd0) || ({16'd0, len_w} > 32'(MEM_SIZE));
    assign last_word  = (idx_q == len_q - 16'd1);
    assign boot_done  = (state_q == BOOT_DONE);
    assign boot_error = (state_q == BOOT_ERROR);
    assign error_code = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        // Timeout only fires on a cycle with no handshake, so it never races a byte.
        if (counting && !hs && (tmo_q == TMO_LAST)) begin
            state_d = BOOT_ERROR;
            err_d   = ERR_TIMEOUT;
        end else begin
            case (state_q)
                BOOT_IDLE:    if (hs && rx_data == BOOT_SYNC) state_d = BOOT_LEN_HI;
                BOOT_LEN_HI:  if (hs) state_d = BOOT_LEN_LO;
                BOOT_LEN_LO: begin
                    if (hs) begin
                        if (len_bad) begin
                            state_d = BOOT_ERROR;
                            err_d   = ERR_LEN;
                        end else begin
                            state_d = BOOT_DATA_HI;
                        end
                    end
                end
                BOOT_DATA_HI: if (hs) state_d = BOOT_DATA_LO;
                BOOT_DATA_LO: if (hs) state_d = last_word ? BOOT_CHECK : BOOT_DATA_HI;
                BOOT_CHECK: begin
                    if (hs) begin
                        if (rx_data == csum_q) begin
                            state_d = BOOT_DONE;
                        end else begin
                            state_d = BOOT_ERROR;
                            err_d   = ERR_CSUM;
                        end
                    end
                end
                BOOT_DONE, BOOT_ERROR: begin
                    // A bypassed loader must never leave Done, so it can never touch RAM.
                    if (boot_req && !BYPASS_BOOT) begin
                        state_d = BOOT_IDLE;
                        err_d   = ERR_NONE;
                    end
                end
                default: state_d = BOOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_q  <= '0;
            len_q     <= '0;
            hi_q      <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (counting && !hs) tmo_q <= tmo_q + 1'b1;
            else                 tmo_q <= '0;
            if (hs) begin
                case (state_q)
                    BOOT_LEN_HI: len_hi_q <= rx_data;
                    BOOT_LEN_LO: begin
                        len_q  <= len_w;
                        idx_q  <= '0;
                        csum_q <= '0;
                    end
                    BOOT_DATA_HI: begin
                        hi_q   <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                    end
                    BOOT_DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx_q[ADDR_WIDTH-1:0];
                        mem_wdata <= DATA_WIDTH'({hi_q, rx_data});
                        idx_q     <= idx_q + 16'd1;
                        csum_q    <= csum_q ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and randomized frames checked against a stream-parsing reference model.
module tb_boot_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        boot_done, boot_error;
    logic [1:0]  error_code;

    logic        b_rx_ready, b_we, b_done, b_error;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata;
    logic [1:0]  b_code;
    logic [7:0]  b_rx_data = 8'h00;
    logic        b_rx_valid = 1'b0;
    logic        b_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int b_writes = 0;

    logic [25:0] got_wr[$];
    logic [25:0] exp_wr[$];
    logic        exp_done, exp_err;
    logic [1:0]  exp_code;
    bq_t         frm;

    always #5 clk = ~clk;

    boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_SIZE(1024),
                  .TIMEOUT_CYCLES(16), .BYPASS_BOOT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .boot_req(boot_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .boot_done(boot_done), .boot_error(boot_error), .error_code(error_code));

    boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_SIZE(1024),
                  .TIMEOUT_CYCLES(16), .BYPASS_BOOT(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .boot_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .boot_done(b_done), .boot_error(b_error), .error_code(b_code));

    always @(negedge clk) begin
        if (mem_we === 1'b1) got_wr.push_back({mem_addr, mem_wdata});
        if (b_we === 1'b1) b_writes++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: scan for sync, read count, collect words, compare XOR of data bytes.
    function automatic void model_frame(input bq_t s);
        int i = 0;
        int len;
        logic [7:0] cs = 8'h00;
        exp_wr.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'd0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        len = int'({s[i+1], s[i+2]});
        i += 3;
        if (len == 0 || len > 1024) begin
            exp_err = 1'b1; exp_code = 2'd1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            exp_wr.push_back({w[9:0], s[i], s[i+1]});
            cs = cs ^ s[i] ^ s[i+1];
            i += 2;
        end
        if (s[i] == cs) exp_done = 1'b1;
        else begin exp_err = 1'b1; exp_code = 2'd2; end
    endfunction

    task automatic send_raw(input bq_t s, input int max_gap);
        for (int i = 0; i < s.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk); rx_valid = 1'b0;
            end
            @(negedge clk); rx_valid = 1'b1; rx_data = s[i];
        end
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clk); boot_req = 1'b1;
        @(negedge clk); boot_req = 1'b0;
    endtask

    task automatic gen_frame(input int len, input bit corrupt, input int pre);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        frm.delete();
        repeat (pre) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            frm.push_back(b);
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(len >> 8));
        frm.push_back(8'(len));
        for (int i = 0; i < 2 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            frm.push_back(b);
            cs ^= b;
        end
        frm.push_back(corrupt ? ~cs : cs);
    endtask

    task automatic run_frame(input string name, input bq_t s, input int max_gap);
        got_wr.delete();
        model_frame(s);
        send_raw(s, max_gap);
        n_tests++;
        if (boot_done !== exp_done) begin
            n_fail++; $display("FAIL %s boot_done got %b exp %b", name, boot_done, exp_done);
        end
        n_tests++;
        if (boot_error !== exp_err) begin
            n_fail++; $display("FAIL %s boot_error got %b exp %b", name, boot_error, exp_err);
        end
        n_tests++;
        if (error_code !== exp_code) begin
            n_fail++; $display("FAIL %s error_code got %0d exp %0d", name, error_code, exp_code);
        end
        n_tests++;
        if (rx_ready !== !(exp_done || exp_err)) begin
            n_fail++; $display("FAIL %s rx_ready got %b exp %b", name, rx_ready, !(exp_done || exp_err));
        end
        n_tests++;
        if (got_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL %s write count got %0d exp %0d", name, got_wr.size(), exp_wr.size());
        end
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++) begin
            n_tests++;
            if (got_wr[k] !== exp_wr[k]) begin
                n_fail++;
                $display("FAIL %s write %0d got addr %0d data %h exp addr %0d data %h", name, k,
                         got_wr[k][25:16], got_wr[k][15:0], exp_wr[k][25:16], exp_wr[k][15:0]);
            end
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if ({boot_done, boot_error, error_code, rx_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL %s after boot_req done/err/code/ready got %b%b%0d%b exp 0001", name,
                     boot_done, boot_error, error_code, rx_ready);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({rx_ready, mem_we, boot_done, boot_error, error_code} !== 6'b100000) begin
            n_fail++; $display("FAIL reset flags got %b%b%b%b%0d exp 100000", rx_ready, mem_we,
                               boot_done, boot_error, error_code);
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 26'd0) begin
            n_fail++; $display("FAIL reset mem port got addr %0d data %h exp 0/0", mem_addr, mem_wdata);
        end
        n_tests++;
        if ({b_done, b_rx_ready, b_we, b_error, b_code} !== 6'b100000) begin
            n_fail++; $display("FAIL bypass reset done/ready/we/err/code got %b%b%b%b%0d exp 100000",
                               b_done, b_rx_ready, b_we, b_error, b_code);
        end
        n_tests++;
        if ({b_addr, b_wdata} !== 26'd0) begin
            n_fail++; $display("FAIL bypass reset mem port got %0d/%h exp 0/0", b_addr, b_wdata);
        end
    endtask

    task automatic test_basic_frame();
        bq_t s;
        s = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'h12, 8'h34, 8'h23};
        run_frame("basic", s, 0);
        pulse_req();
        check_cleared("basic");
        s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        run_frame("leading_bytes", s, 0);
        pulse_req();
        check_cleared("leading_bytes");
    endtask

    task automatic test_bad_length();
        bq_t s;
        s = '{8'hA5, 8'h00, 8'h00};
        run_frame("len_zero", s, 0);
        pulse_req();
        check_cleared("len_zero");
        s = '{8'hA5, 8'h04, 8'h01};
        run_frame("len_1025", s, 0);
        pulse_req();
        check_cleared("len_1025");
    endtask

    task automatic test_bad_checksum();
        bq_t s;
        s = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        run_frame("bad_csum", s, 1);
        pulse_req();
        check_cleared("bad_csum");
    endtask

    task automatic test_timeout();
        bq_t s;
        s = '{8'hA5, 8'h00};
        send_raw(s, 0);
        repeat (15) @(posedge clk);
        #1;
        n_tests++;
        if (boot_error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early boot_error got %b exp 0", boot_error);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({boot_error, error_code} !== 3'b111) begin
            n_fail++; $display("FAIL timeout boot_error/code got %b/%0d exp 1/3", boot_error, error_code);
        end
        pulse_req();
        check_cleared("timeout");
        repeat (40) @(posedge clk);
        #1;
        n_tests++;
        if ({boot_error, error_code, rx_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL idle_stall err/code/ready got %b/%0d/%b exp 0/0/1",
                               boot_error, error_code, rx_ready);
        end
    endtask

    task automatic test_req_ignored();
        bq_t s;
        got_wr.delete();
        s = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_raw(s, 0);
        pulse_req();
        s = '{8'h34, 8'h26};
        send_raw(s, 0);
        n_tests++;
        if (boot_done !== 1'b1 || got_wr.size() != 1) begin
            n_fail++; $display("FAIL req_ignored done/writes got %b/%0d exp 1/1", boot_done, got_wr.size());
        end else begin
            n_tests++;
            if (got_wr[0] !== {10'd0, 16'h1234}) begin
                n_fail++; $display("FAIL req_ignored write got %h exp 0001234", got_wr[0]);
            end
        end
        pulse_req();
    endtask

    task automatic test_reset_mid();
        bq_t s;
        got_wr.delete();
        s = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_raw(s, 0);
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h34;
        @(posedge clk); #1; rx_valid = 1'b0;
        n_tests++;
        if (got_wr.size() != 0 || boot_done !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid writes/done/ready got %0d/%b/%b exp 0/0/1",
                               got_wr.size(), boot_done, rx_ready);
        end
        s = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_raw(s, 0);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h34;
        @(posedge clk); #1; rst_n = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0 || got_wr.size() != 0) begin
            n_fail++; $display("FAIL reset_strobe mem_we/writes got %b/%0d exp 0/0", mem_we, got_wr.size());
        end
        rst_n = 1'b1;
        s = '{8'hA5, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'h00, 8'h07, 8'h33};
        run_frame("after_reset", s, 0);
        pulse_req();
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            gen_frame($urandom_range(1, 8), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
            run_frame($sformatf("random%0d", f), frm, 3);
            pulse_req();
            check_cleared($sformatf("random%0d", f));
        end
    endtask

    task automatic test_back_to_back();
        gen_frame(1024, 1'b0, 0);
        run_frame("full_1024", frm, 0);
        pulse_req();
        n_tests++;
        if (b_writes != 0 || b_done !== 1'b1) begin
            n_fail++; $display("FAIL bypass writes/done got %0d/%b exp 0/1", b_writes, b_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_bad_length();
        test_bad_checksum();
        test_timeout();
        test_req_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
